// File: rtl/seg_pkg.sv
// Shared constants, state encoding and buffer layout for the multiplexed
// seven-segment display path.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [7:0]  SEG_OFF    = 8'hFF;
    localparam logic [7:0]  SEL_OFF    = 8'hFF;

    // Active-low g..a patterns; entry n is the glyph for hex value n.
    localparam logic [15:0][6:0] HEX7_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  en;
    } disp_buf_t;

    function automatic logic [6:0] hex7_lookup(input logic [3:0] nib);
        return HEX7_LUT[nib];
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Hex nibble to active-low seven-segment pattern (g..a), purely combinational.
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_n_c
);

    assign o_seg_n_c = hex7_lookup(i_hex);

endmodule

// File: rtl/segment_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with a blanking gap per slot
// and tear-free double buffering that swaps only at frame boundaries.
module segment_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic [7:0]  segment,
    output logic [7:0]  select,
    output logic        frame_start
);

    localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      r_state;
    scan_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] r_digit;
    logic [IDX_W-1:0] w_digit_nxt;
    logic             w_boundary;

    disp_buf_t        r_stage;
    disp_buf_t        r_shadow;
    logic             r_pending;

    logic [3:0]       w_nibble;
    logic [6:0]       w_glyph;
    logic [7:0]       w_seg_nxt;
    logic [7:0]       w_sel_nxt;
    logic             w_fs_nxt;

    logic [7:0]       r_segment;
    logic [7:0]       r_select;
    logic             r_frame_start;

    assign w_nibble = 4'(r_shadow.data >> {r_digit, 2'b00});

    hex7seg_decode u_decode (
        .i_hex     (w_nibble),
        .o_seg_n_c (w_glyph)
    );

    // Slot counter, state and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_digit <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_digit_nxt = r_digit;
        w_boundary  = 1'b0;
        w_seg_nxt   = SEG_OFF;
        w_sel_nxt   = SEL_OFF;
        w_fs_nxt    = (r_state == ST_BLANK) && (r_digit == '0) && (r_cnt == '0);

        case (r_state)
            ST_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (r_shadow.en[r_digit]) begin
                    w_sel_nxt = SEL_OFF ^ (8'(1) << r_digit);
                    w_seg_nxt = {~r_shadow.dp[r_digit], w_glyph};
                end
                if (r_cnt == SLOT_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_digit_nxt = r_digit + IDX_W'(1);
                    w_boundary  = (r_digit == DIGIT_LAST);
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Staging/shadow buffers; a load coinciding with the boundary stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage   <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (load) begin
                r_stage <= '{data: data_in, dp: dp_in, en: digit_en};
            end
            if (w_boundary && r_pending) begin
                r_shadow <= r_stage;
            end
            if (load) begin
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Output registers, one cycle behind the scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_segment     <= SEG_OFF;
            r_select      <= SEL_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_segment     <= w_seg_nxt;
            r_select      <= w_sel_nxt;
            r_frame_start <= w_fs_nxt;
        end
    end

    assign segment     = r_segment;
    assign select      = r_select;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_segment_scan_driver.sv
// Directed bench for segment_scan_driver with 10-cycle slots and 2-cycle blanking.
module tb_segment_scan_driver;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        load;
    logic [7:0]  segment;
    logic [7:0]  select;
    logic        frame_start;

    int n_checks;
    int n_err;

    logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    segment_scan_driver #(
        .DIGIT_CYCLES (10),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .load        (load),
        .segment     (segment),
        .select      (select),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs for output cycle j (0..79) of a frame.
    function automatic void exp_out(input int j, input logic [31:0] d, input logic [7:0] dp,
                                    input logic [7:0] en, output logic [7:0] seg,
                                    output logic [7:0] sel);
        int k;
        int c;
        k   = j / 10;
        c   = j % 10;
        seg = 8'hFF;
        sel = 8'hFF;
        if (c >= 2 && en[k]) begin
            sel = ~(8'h01 << k);
            seg = lut[d[k*4 +: 4]];
            if (dp[k]) seg[7] = 1'b0;
        end
    endfunction

    // Checks output cycles j0..j1; assumes the current negedge is cycle j0.
    task automatic scan_range(input int j0, input int j1, input logic [31:0] d,
                              input logic [7:0] dp, input logic [7:0] en);
        logic [7:0] es;
        logic [7:0] esel;
        for (int j = j0; j <= j1; j++) begin
            if (j != j0) @(negedge clk);
            exp_out(j, d, dp, en, es, esel);
            chk($sformatf("seg j%0d", j), 32'(segment), 32'(es));
            chk($sformatf("sel j%0d", j), 32'(select), 32'(esel));
            chk($sformatf("onehot j%0d", j), 32'($countones(~select) <= 1), 32'(1));
            chk($sformatf("fs j%0d", j), 32'(frame_start), 32'(j == 0));
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 200);
        if (!frame_start) chk("fs_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        data_in  = d;
        dp_in    = dp;
        digit_en = en;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    initial begin
        int n;
        int lit;
        logic [7:0] es;
        logic [7:0] esel;
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        data_in  = '0;
        dp_in    = '0;
        digit_en = '0;
        load     = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(segment), 32'hFF);
        chk("rst_sel", 32'(select), 32'hFF);
        chk("rst_fs", 32'(frame_start), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("first_fs", 32'(frame_start), 32'(1));

        // Frame period and dark display without any load.
        n   = 0;
        lit = 0;
        do begin
            @(negedge clk);
            n++;
            if (select != 8'hFF || segment != 8'hFF) lit++;
        end while (!frame_start && n < 200);
        chk("fs_period", 32'(n), 32'(80));
        chk("dark_noload", 32'(lit), 32'(0));

        // Basic scan.
        do_load(32'h76543210, 8'h00, 8'hFF);
        wait_fs();
        scan_range(0, 79, 32'h76543210, 8'h00, 8'hFF);

        // Enable mask and decimal point.
        wait_fs();
        do_load(32'hFEDCBA98, 8'h04, 8'h05);
        wait_fs();
        scan_range(0, 79, 32'hFEDCBA98, 8'h04, 8'h05);

        // Tear-free update: load during digit 3.
        wait_fs();
        scan_range(0, 35, 32'hFEDCBA98, 8'h04, 8'h05);
        data_in  = 32'h13579BDF;
        dp_in    = 8'hA0;
        digit_en = 8'hFF;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        scan_range(36, 79, 32'hFEDCBA98, 8'h04, 8'h05);
        wait_fs();
        scan_range(0, 79, 32'h13579BDF, 8'hA0, 8'hFF);

        // Load on boundary: pending A swaps in now, B waits a frame.
        wait_fs();
        scan_range(0, 40, 32'h13579BDF, 8'hA0, 8'hFF);
        do_load(32'h0000AAAA, 8'h01, 8'h0F);
        scan_range(41, 79, 32'h13579BDF, 8'hA0, 8'hFF);
        do_load(32'hCDEF0123, 8'h80, 8'hFF);
        scan_range(0, 79, 32'h0000AAAA, 8'h01, 8'h0F);
        wait_fs();
        scan_range(0, 79, 32'hCDEF0123, 8'h80, 8'hFF);

        // Asynchronous reset while digit 2 is lit, with a load pending.
        wait_fs();
        scan_range(0, 25, 32'hCDEF0123, 8'h80, 8'hFF);
        do_load(32'h11111111, 8'hFF, 8'hFF);
        exp_out(26, 32'hCDEF0123, 8'h80, 8'hFF, es, esel);
        chk("lit_before_rst", 32'(select), 32'(esel));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_seg", 32'(segment), 32'hFF);
        chk("async_rst_sel", 32'(select), 32'hFF);
        chk("async_rst_fs", 32'(frame_start), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_fs();
        scan_range(0, 79, 32'h0, 8'h00, 8'h00);
        wait_fs();
        scan_range(0, 79, 32'h0, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/segment_scan_driver.md
# segment_scan_driver

Time-multiplexed driver for the 8-digit seven-segment display. It sits downstream of the counter/datapath logic and replaces the single-digit static decoder when more than one digit must be shown. It double-buffers eight hex nibbles, decimal points and digit enables, then scans one digit at a time with a blanking gap between digits to suppress ghosting. Display updates are tear-free: new contents are adopted only at frame boundaries.

## Interface
- DIGIT_CYCLES, 50000: clk cycles per digit slot (1 kHz per digit at 50 MHz).
- BLANK_CYCLES, 500: leading cycles of each slot with all outputs dark. Legal range 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.

- clk  in  1: system clock.
- rst  in  1: reset, asynchronous, active-high.
- data_in  in  32: nibble k (bits 4k+3:4k) is the hex value for digit k.
- dp_in  in  8: bit k lights the decimal point of digit k.
- digit_en  in  8: bit k enables digit k. A disabled digit is dark for its whole slot.
- load  in  1: single-cycle strobe that captures data_in, dp_in and digit_en into staging.
- segment  out  8: active-low; bit 7 = dp, bits 6:0 = g..a.
- select  out  8: active-low one-hot digit select; bit k = digit k.
- frame_start  out  1: one-cycle pulse marking the first cycle of digit 0's slot.

## Operation
- Three register sets: staging (written by load), shadow (drives the display), and a pending flag.
- On load, staging captures all three inputs and pending is set. Back-to-back loads overwrite staging; the last one wins.
- Per-slot FSM:
  - BLANK lasts BLANK_CYCLES cycles. segment = 8'hFF, select = 8'hFF.
  - SHOW lasts DIGIT_CYCLES − BLANK_CYCLES cycles. select bit k = 0 if shadow digit_en[k] = 1. segment = decode(nibble k) with bit 7 = ~dp[k].
  - After SHOW, the digit index advances k → k+1, wrapping 7 → 0, and the FSM returns to BLANK.
- Frame boundary is the transition into BLANK of digit 0. If pending = 1 in the cycle before the boundary, staging is copied to shadow and pending clears.
- Load and boundary in the same cycle: the boundary transfer uses the old staging contents; the new load stays pending for the next frame.
- A disabled digit still consumes its full slot, so per-digit brightness is independent of the enable mask.
- Decode, active-low with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

## Timing
- Slot counter width: clog2(DIGIT_CYCLES). Counts 0..DIGIT_CYCLES−1; BLANK when count < BLANK_CYCLES.
- Frame period: exactly 8·DIGIT_CYCLES cycles.
- segment, select and frame_start are registered and lag FSM state by one cycle.
- frame_start is high in the first output cycle of digit 0's BLANK.
- Reset values: FSM = BLANK, digit index 0, slot counter 0, shadow and staging all zero, pending 0. Outputs: segment = 8'hFF, select = 8'hFF, frame_start = 0.
- First post-reset frame_start: the first clk edge after rst deasserts.
- Reset mid-frame forces all outputs dark asynchronously and discards any pending load.
- Display latency from load: the pending frame boundary, then one cycle of output register, then BLANK_CYCLES before the digit lights. Worst case is 8·DIGIT_CYCLES + BLANK_CYCLES + 1 cycles.
- Glitch-free select: at most one select bit is low in any cycle. No select bit is ever low during BLANK.

## Structure
- Shared package seg_pkg holds:
  - NUM_DIGITS = 8
  - SEG_OFF = 8'hFF
  - SEL_OFF = 8'hFF
  - the 16-entry active-low hex decode constants
  - FSM state encoding (ST_BLANK, ST_SHOW)
- One combinational sub-module, hex7seg_decode (4-bit in, 7-bit active-low out), shared with other display paths.
- Counter, FSM, buffers and output registers live in segment_scan_driver.

## Test plan
All scenarios use DIGIT_CYCLES = 10 and BLANK_CYCLES = 2.
- Reset: hold rst, check segment = FF, select = FF, frame_start = 0. Release and check the frame_start period is exactly 80 cycles. With no load, select stays FF forever.
- Basic scan: load data 0x76543210, dp 0x00, en 0xFF. In the following frame:
  - digit k shows its decode (digit 0 → C0, digit 7 → F8) with select = ~(1<<k) for 8 cycles per slot;
  - select = FF for 2 cycles per slot;
  - never two select bits low at once.
- Enable and dp: load en 0x05 and dp 0x04. Only digits 0 and 2 light, digit 2 shows segment bit 7 = 0, and slot timing is unchanged.
- Tear-free update: apply a load mid-frame (digit 3). Digits 4–7 keep the old values; the new values appear from the next frame_start.
- Load on boundary: assert load in the cycle before frame_start. Old staging is shown this frame and the new data in the next.
- Reset mid-SHOW: assert rst asynchronously while a digit is lit. Outputs go to FF with no clock edge, pending clears, and the display stays dark after release until the next load.
